// File: rtl/time_set_input_12.sv
// rtl/time_set_input_12.sv - key-driven 12-hour time entry front end with commit strobe
//
// Purpose: debounces MODE/INC/DEC keys, walks hour/minute/second/AM-PM fields,
// and emits the edited time as 24-hour binary with a one-cycle load strobe.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   key_mode, key_inc, key_dec      raw asynchronous keys, active-high
//   cur_hour/minute/second          running time, snapshot on entry to edit
//   set_active                      1 while editing or committing
//   set_field                       0=HOUR 1=MIN 2=SEC 3=AMPM (0 otherwise)
//   set_hour/minute/second/pm       edited time (hour in 24-hour form)
//   load                            one-cycle commit strobe

module time_set_input_12 #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  output logic       set_active,
  output logic [1:0] set_field,
  output logic [4:0] set_hour,
  output logic [5:0] set_minute,
  output logic [5:0] set_second,
  output logic       set_pm,
  output logic       load
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOUR   = 3'd1,
    S_MIN    = 3'd2,
    S_SEC    = 3'd3,
    S_AMPM   = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Key conditioning. Bit 0 = MODE, 1 = INC, 2 = DEC.
  // Pipeline: 2 sync flops, DEBOUNCE_CYCLES equal samples, 1 registered edge
  // detect, so the press pulse lands on the (2+DEBOUNCE_CYCLES+1)-th edge
  // counting the edge that first samples the new raw level.
  // ---------------------------------------------------------------------------
  logic [2:0]     raw;
  logic [2:0]     sync1, sync2, db, db_d, press;
  logic [DCW-1:0] db_cnt [3];

  assign raw = {key_dec, key_inc, key_mode};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_d  <= db;
      press <= db & ~db_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != db[i]) begin
          // This sample is the DEBOUNCE_CYCLES-th consecutive differing one.
          if (db_cnt[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // MODE wins over INC/DEC; INC and DEC together cancel each other.
  logic p_mode, p_inc, p_dec;
  assign p_mode = press[0];
  assign p_inc  = press[1] & ~press[2] & ~press[0];
  assign p_dec  = press[2] & ~press[1] & ~press[0];

  logic edit_state, accepted, timeout_hit;
  assign edit_state = (state == S_HOUR) || (state == S_MIN) ||
                      (state == S_SEC)  || (state == S_AMPM);
  assign accepted   = edit_state && (p_mode || p_inc || p_dec);

  // ---------------------------------------------------------------------------
  // Inactivity timeout: counts edit-state cycles since the last accepted press.
  // ---------------------------------------------------------------------------
  logic [TCW-1:0] tcnt;

  assign timeout_hit = edit_state && !accepted && (tcnt == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !edit_state || accepted) tcnt <= '0;
    else                                tcnt <= tcnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register, next-state logic, output logic.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (p_mode) state_next = S_HOUR;
      S_HOUR:   if (p_mode) state_next = S_MIN;    else if (timeout_hit) state_next = S_IDLE;
      S_MIN:    if (p_mode) state_next = S_SEC;    else if (timeout_hit) state_next = S_IDLE;
      S_SEC:    if (p_mode) state_next = S_AMPM;   else if (timeout_hit) state_next = S_IDLE;
      S_AMPM:   if (p_mode) state_next = S_COMMIT; else if (timeout_hit) state_next = S_IDLE;
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    set_active = 1'b0;
    set_field  = 2'd0;
    load       = 1'b0;
    case (state)
      S_HOUR:   begin set_active = 1'b1; set_field = 2'd0; end
      S_MIN:    begin set_active = 1'b1; set_field = 2'd1; end
      S_SEC:    begin set_active = 1'b1; set_field = 2'd2; end
      S_AMPM:   begin set_active = 1'b1; set_field = 2'd3; end
      S_COMMIT: begin set_active = 1'b1; load = 1'b1; end
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Edit registers. h12 resets to 12 AM so set_hour reads 0 after reset.
  // ---------------------------------------------------------------------------
  logic [3:0] h12;
  logic       pm;
  logic [5:0] edit_min, edit_sec;

  always_ff @(posedge clk) begin
    if (rst) begin
      h12      <= 4'd12;
      pm       <= 1'b0;
      edit_min <= 6'd0;
      edit_sec <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (p_mode) begin
            if (cur_hour == 5'd0 || cur_hour > 5'd23) begin
              h12 <= 4'd12;
              pm  <= 1'b0;
            end else if (cur_hour < 5'd12) begin
              h12 <= cur_hour[3:0];
              pm  <= 1'b0;
            end else if (cur_hour == 5'd12) begin
              h12 <= 4'd12;
              pm  <= 1'b1;
            end else begin
              h12 <= 4'(cur_hour - 5'd12);
              pm  <= 1'b1;
            end
            edit_min <= (cur_minute > 6'd59) ? 6'd0 : cur_minute;
            edit_sec <= (cur_second > 6'd59) ? 6'd0 : cur_second;
          end
        end
        S_HOUR: begin
          if (p_inc) h12 <= (h12 == 4'd12) ? 4'd1  : h12 + 4'd1;
          if (p_dec) h12 <= (h12 == 4'd1)  ? 4'd12 : h12 - 4'd1;
        end
        S_MIN: begin
          if (p_inc) edit_min <= (edit_min == 6'd59) ? 6'd0  : edit_min + 6'd1;
          if (p_dec) edit_min <= (edit_min == 6'd0)  ? 6'd59 : edit_min - 6'd1;
        end
        S_SEC: begin
          if (p_inc) edit_sec <= (edit_sec == 6'd59) ? 6'd0  : edit_sec + 6'd1;
          if (p_dec) edit_sec <= (edit_sec == 6'd0)  ? 6'd59 : edit_sec - 6'd1;
        end
        S_AMPM: begin
          if (p_inc || p_dec) pm <= ~pm;
        end
        default: ;
      endcase
    end
  end

  // 12-hour to 24-hour: 12 AM -> 0, 12 PM -> 12, other PM hours +12.
  always_comb begin
    set_hour = {1'b0, h12};
    if (pm) begin
      if (h12 != 4'd12) set_hour = {1'b0, h12} + 5'd12;
    end else begin
      if (h12 == 4'd12) set_hour = 5'd0;
    end
  end

  assign set_minute = edit_min;
  assign set_second = edit_sec;
  assign set_pm     = pm;

endmodule

// File: tb/tb_time_set_input_12.sv
// tb/tb_time_set_input_12.sv - self-checking bench for time_set_input_12

module tb_time_set_input_12;

  localparam int D = 16;
  localparam int T = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_mode, key_inc, key_dec;
  logic [4:0] cur_hour;
  logic [5:0] cur_minute, cur_second;
  logic       set_active;
  logic [1:0] set_field;
  logic [4:0] set_hour;
  logic [5:0] set_minute, set_second;
  logic       set_pm;
  logic       load;

  time_set_input_12 #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .set_active(set_active), .set_field(set_field),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .set_pm(set_pm), .load(load)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time held as 24-hour integers, field index, edit flag.
  int m_active = 0, m_field = 0, m_hour = 0, m_min = 0, m_sec = 0;
  int exp_loads = 0, e_ld_h = 0, e_ld_m = 0, e_ld_s = 0;

  // Load observer.
  int load_cnt = 0, ld_h = 0, ld_m = 0, ld_s = 0;
  always @(negedge clk) begin
    if (load) begin
      load_cnt <= load_cnt + 1;
      ld_h     <= int'(set_hour);
      ld_m     <= int'(set_minute);
      ld_s     <= int'(set_second);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":active"}, 32'(set_active), m_active);
    chk({ctx, ":field"},  32'(set_field),  m_field);
    chk({ctx, ":hour"},   32'(set_hour),   m_hour);
    chk({ctx, ":minute"}, 32'(set_minute), m_min);
    chk({ctx, ":second"}, 32'(set_second), m_sec);
    chk({ctx, ":pm"},     32'(set_pm),     (m_hour >= 12) ? 1 : 0);
    chk({ctx, ":loads"},  load_cnt,        exp_loads);
    chk({ctx, ":ld_hour"}, ld_h, e_ld_h);
    chk({ctx, ":ld_min"},  ld_m, e_ld_m);
    chk({ctx, ":ld_sec"},  ld_s, e_ld_s);
  endtask

  task automatic model_reset();
    m_active = 0; m_field = 0; m_hour = 0; m_min = 0; m_sec = 0;
  endtask

  task automatic apply(input bit m, input bit i, input bit d);
    int base;
    if (m) begin
      if (m_active == 0) begin
        m_hour   = (cur_hour > 23)   ? 0 : int'(cur_hour);
        m_min    = (cur_minute > 59) ? 0 : int'(cur_minute);
        m_sec    = (cur_second > 59) ? 0 : int'(cur_second);
        m_active = 1;
        m_field  = 0;
      end else if (m_field == 3) begin
        m_active = 0;
        m_field  = 0;
        exp_loads++;
        e_ld_h = m_hour; e_ld_m = m_min; e_ld_s = m_sec;
      end else begin
        m_field++;
      end
    end else if (m_active != 0 && i != d) begin
      case (m_field)
        0: begin
          base   = (m_hour >= 12) ? 12 : 0;
          m_hour = base + ((m_hour % 12) + (i ? 1 : 11)) % 12;
        end
        1: m_min  = (m_min + (i ? 1 : 59)) % 60;
        2: m_sec  = (m_sec + (i ? 1 : 59)) % 60;
        default: m_hour = (m_hour + 12) % 24;
      endcase
    end
  endtask

  task automatic drive(input bit m, input bit i, input bit d, input int hold);
    @(negedge clk);
    key_mode = m; key_inc = i; key_dec = d;
    repeat (hold) @(negedge clk);
    key_mode = 0; key_inc = 0; key_dec = 0;
    repeat (D + 8) @(negedge clk);
  endtask

  task automatic step(input string tag, input bit m, input bit i, input bit d);
    drive(m, i, d, D + 6);
    apply(m, i, d);
    check_all(tag);
  endtask

  initial begin
    int r, guard;
    rst = 1; key_mode = 0; key_inc = 0; key_dec = 0;
    cur_hour = 0; cur_minute = 0; cur_second = 0;
    repeat (3) @(negedge clk);
    model_reset();
    check_all("reset");
    rst = 0;

    // 1) midnight snapshot, INC hour
    step("t1_mode", 1, 0, 0);
    step("t1_inc", 0, 1, 0);
    repeat (4) step("t1_exit", 1, 0, 0);

    // 2) wrap cases from 23:59:59
    cur_hour = 23; cur_minute = 59; cur_second = 59;
    step("t2_mode", 1, 0, 0);
    step("t2_hinc", 0, 1, 0);
    step("t2_m", 1, 0, 0);
    step("t2_minc", 0, 1, 0);
    step("t2_s", 1, 0, 0);
    step("t2_sdec", 0, 0, 1);
    step("t2_a", 1, 0, 0);
    step("t2_commit", 1, 0, 0);

    // 3) full pass with and without AM/PM toggle
    cur_hour = 13; cur_minute = 5; cur_second = 7;
    repeat (5) step("t3_pass", 1, 0, 0);
    repeat (4) step("t3_walk", 1, 0, 0);
    step("t3_toggle", 0, 1, 0);
    step("t3_commit", 1, 0, 0);

    // 4) glitch, exact latency, long hold
    drive(1, 0, 0, D - 1);
    repeat (D) @(negedge clk);
    check_all("t4_glitch");
    cur_hour = 7; cur_minute = 30; cur_second = 0;
    @(negedge clk);
    key_mode = 1;
    for (int k = 1; k <= D + 4; k++) begin
      @(negedge clk);
      if (k == D) key_mode = 0;
      if (k == D + 3) chk("t4_lat_before", 32'(set_active), 0);
      if (k == D + 4) chk("t4_lat_at", 32'(set_active), 1);
    end
    repeat (D + 8) @(negedge clk);
    apply(1, 0, 0);
    check_all("t4_latency");
    drive(0, 1, 0, 3 * D);
    apply(0, 1, 0);
    check_all("t4_longhold");

    // 5) simultaneous presses
    step("t5_mode_inc", 1, 1, 0);
    step("t5_inc_dec", 0, 1, 1);

    // 6) timeout in MIN, then reset in SEC
    repeat (900) @(negedge clk);
    chk("t6_before_timeout", 32'(set_active), 1);
    repeat (200) @(negedge clk);
    m_active = 0; m_field = 0;
    check_all("t6_timeout");
    cur_hour = 18; cur_minute = 44; cur_second = 12;
    step("t6_enter", 1, 0, 0);
    step("t6_min", 1, 0, 0);
    step("t6_sec", 1, 0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    check_all("t6_reset");

    // Randomized sessions against the model
    for (int n = 0; n < 20; n++) begin
      cur_hour   = 5'($urandom_range(0, 31));
      cur_minute = 6'($urandom_range(0, 63));
      cur_second = 6'($urandom_range(0, 63));
      step("rnd_enter", 1, 0, 0);
      for (int j = 0; j < 10 && m_active != 0; j++) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2: step("rnd_mode", 1, 0, 0);
          3, 4:    step("rnd_inc", 0, 1, 0);
          5, 6:    step("rnd_dec", 0, 0, 1);
          7:       step("rnd_incdec", 0, 1, 1);
          8:       step("rnd_modeinc", 1, 1, 0);
          default: step("rnd_modedec", 1, 0, 1);
        endcase
      end
      guard = 0;
      while (m_active != 0 && guard < 5) begin
        step("rnd_finish", 1, 0, 0);
        guard++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
